// File: rtl/ad_ser_fifo.sv
// ad_ser_fifo: synchronises an AD request/strobe pair, buffers captured words in a
// DEPTH-deep FIFO and streams each word out serially with a programmable gap.
module ad_ser_fifo #(
  parameter int DW        = 8,
  parameter int DEPTH     = 4,
  parameter int MSB_FIRST = 1,
  parameter int GAP       = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] databus,
  input  logic          use_p_in_bus,
  input  logic          nGet_AD_data,
  output logic          Dbit_out,
  output logic          Dbit_ena,
  output logic          fifo_empty,
  output logic          fifo_full,
  output logic          overflow,
  output logic          orphan,
  output logic [15:0]   word_cnt,
  output logic [1:0]    state_dbg
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(DW - 1);
  localparam logic [7:0]    GAP_LAST = (GAP > 0) ? 8'(GAP - 1) : 8'd0;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP_ST = 2'd2} state_t;

  logic [2:0]    nget_sync_q, nget_sync_d;
  logic [2:0]    usep_sync_q, usep_sync_d;
  logic          armed_q, armed_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          overflow_q, overflow_d;
  logic          orphan_q, orphan_d;
  state_t        state_q, state_d;
  logic [DW-1:0] shreg_q, shreg_d;
  logic [BW-1:0] bitcnt_q, bitcnt_d;
  logic [7:0]    gapcnt_q, gapcnt_d;
  logic          dout_q, dout_d;
  logic          dena_q, dena_d;
  logic [15:0]   word_cnt_q, word_cnt_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];

  logic nget_fall, usep_rise, pop, wr_en;

  // Serial output contract: Dbit_out carries a data bit only while Dbit_ena is high;
  // Dbit_ena stays high for exactly DW consecutive clocks per word, with no backpressure.
  always_comb begin
    nget_sync_d = {nget_sync_q[1:0], nGet_AD_data};
    usep_sync_d = {usep_sync_q[1:0], use_p_in_bus};
    nget_fall   = nget_sync_q[2] & ~nget_sync_q[1];
    usep_rise   = ~usep_sync_q[2] & usep_sync_q[1];

    state_d    = state_q;
    shreg_d    = shreg_q;
    bitcnt_d   = bitcnt_q;
    gapcnt_d   = gapcnt_q;
    word_cnt_d = word_cnt_q;
    dout_d     = 1'b0;
    dena_d     = 1'b0;
    pop        = 1'b0;

    case (state_q)
      IDLE: begin
        if (!empty_q) begin
          pop      = 1'b1;
          shreg_d  = mem_q[rd_ptr_q];
          bitcnt_d = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        dena_d   = 1'b1;
        dout_d   = (MSB_FIRST != 0) ? shreg_q[DW-1] : shreg_q[0];
        shreg_d  = (MSB_FIRST != 0) ? {shreg_q[DW-2:0], 1'b0} : {1'b0, shreg_q[DW-1:1]};
        bitcnt_d = bitcnt_q + BW'(1);
        if (bitcnt_q == BIT_LAST) begin
          word_cnt_d = word_cnt_q + 16'd1;
          gapcnt_d   = '0;
          state_d    = (GAP > 0) ? GAP_ST : IDLE;
        end
      end
      GAP_ST: begin
        gapcnt_d = gapcnt_q + 8'd1;
        // The last gap clock doubles as the pop cycle so queued words sit exactly GAP clocks apart.
        if (gapcnt_q == GAP_LAST) begin
          if (!empty_q) begin
            pop      = 1'b1;
            shreg_d  = mem_q[rd_ptr_q];
            bitcnt_d = '0;
            state_d  = SHIFT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    armed_d    = armed_q;
    overflow_d = overflow_q;
    orphan_d   = orphan_q;
    wr_en      = 1'b0;
    if (usep_rise) begin
      if (armed_q) begin
        armed_d = 1'b0;
        if (!full_q || pop) wr_en = 1'b1;
        else overflow_d = 1'b1;
      end else begin
        orphan_d = 1'b1;
      end
    end
    if (nget_fall) armed_d = 1'b1;

    mem_d = mem_q;
    if (wr_en) mem_d[wr_ptr_q] = databus;
    wr_ptr_d = wr_ptr_q + (wr_en ? AW'(1) : AW'(0));
    rd_ptr_d = rd_ptr_q + (pop ? AW'(1) : AW'(0));
    cnt_d    = cnt_q + CW'(wr_en) - CW'(pop);
    empty_d  = (cnt_d == '0);
    full_d   = (cnt_d == CNT_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nget_sync_q <= 3'b111;
      usep_sync_q <= 3'b000;
      armed_q     <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      orphan_q    <= 1'b0;
      state_q     <= IDLE;
      shreg_q     <= '0;
      bitcnt_q    <= '0;
      gapcnt_q    <= '0;
      dout_q      <= 1'b0;
      dena_q      <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      nget_sync_q <= nget_sync_d;
      usep_sync_q <= usep_sync_d;
      armed_q     <= armed_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
      orphan_q    <= orphan_d;
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bitcnt_q    <= bitcnt_d;
      gapcnt_q    <= gapcnt_d;
      dout_q      <= dout_d;
      dena_q      <= dena_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  // Storage needs no reset: the cleared pointers make stale contents unreachable.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign Dbit_out   = dout_q;
  assign Dbit_ena   = dena_q;
  assign fifo_empty = empty_q;
  assign fifo_full  = full_q;
  assign overflow   = overflow_q;
  assign orphan     = orphan_q;
  assign word_cnt   = word_cnt_q;
  assign state_dbg  = state_q;
endmodule

// File: tb/tb_ad_ser_fifo.sv
// Bench for ad_ser_fifo: three instances (default, 16-bit LSB-first, slow 16-bit)
// driven by directed request/strobe pairs, checked by per-instance serial monitors.
module tb_ad_ser_fifo;
  logic        clk;
  logic        rst;
  logic [15:0] bus  [3];
  logic        usep [3];
  logic        nget [3];
  logic        dout [3];
  logic        dena [3];
  logic        emp  [3];
  logic        full [3];
  logic        ovf  [3];
  logic        orph [3];
  logic [15:0] wcnt [3];
  logic [1:0]  sdbg [3];

  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  logic [15:0] exp_q2[$];

  int n_checks = 0;
  int n_errors = 0;
  int idle_bad = 0;
  int words_seen [3] = '{0, 0, 0};
  int last_gap   [3] = '{-1, -1, -1};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  ad_ser_fifo #(.DW(8), .DEPTH(4), .MSB_FIRST(1), .GAP(2)) u_dut_a (
    .clk(clk), .rst(rst), .databus(bus[0][7:0]), .use_p_in_bus(usep[0]),
    .nGet_AD_data(nget[0]), .Dbit_out(dout[0]), .Dbit_ena(dena[0]),
    .fifo_empty(emp[0]), .fifo_full(full[0]), .overflow(ovf[0]),
    .orphan(orph[0]), .word_cnt(wcnt[0]), .state_dbg(sdbg[0]));

  ad_ser_fifo #(.DW(16), .DEPTH(4), .MSB_FIRST(0), .GAP(2)) u_dut_b (
    .clk(clk), .rst(rst), .databus(bus[1]), .use_p_in_bus(usep[1]),
    .nGet_AD_data(nget[1]), .Dbit_out(dout[1]), .Dbit_ena(dena[1]),
    .fifo_empty(emp[1]), .fifo_full(full[1]), .overflow(ovf[1]),
    .orphan(orph[1]), .word_cnt(wcnt[1]), .state_dbg(sdbg[1]));

  ad_ser_fifo #(.DW(16), .DEPTH(4), .MSB_FIRST(1), .GAP(255)) u_dut_c (
    .clk(clk), .rst(rst), .databus(bus[2]), .use_p_in_bus(usep[2]),
    .nGet_AD_data(nget[2]), .Dbit_out(dout[2]), .Dbit_ena(dena[2]),
    .fifo_empty(emp[2]), .fifo_full(full[2]), .overflow(ovf[2]),
    .orphan(orph[2]), .word_cnt(wcnt[2]), .state_dbg(sdbg[2]));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // scoreboard
  function automatic void push_exp(input int idx, input logic [15:0] v);
    case (idx)
      0:       exp_q0.push_back(v);
      1:       exp_q1.push_back(v);
      default: exp_q2.push_back(v);
    endcase
  endfunction

  function automatic void pop_exp(input int idx, output logic [15:0] v, output bit ok);
    ok = 1'b0;
    v  = '0;
    case (idx)
      0:       if (exp_q0.size() > 0) begin v = exp_q0.pop_front(); ok = 1'b1; end
      1:       if (exp_q1.size() > 0) begin v = exp_q1.pop_front(); ok = 1'b1; end
      default: if (exp_q2.size() > 0) begin v = exp_q2.pop_front(); ok = 1'b1; end
    endcase
  endfunction

  task automatic monitor(input int idx, input int dw, input bit msb);
    logic [15:0] w = '0;
    logic [15:0] got;
    logic [15:0] exp;
    logic [15:0] mask;
    bit ok;
    int n = 0;
    int low_run = 0;
    bit seen = 1'b0;
    mask = (dw >= 16) ? 16'hFFFF : 16'((32'd1 << dw) - 32'd1);
    forever begin
      @(negedge clk);
      if (rst) begin
        n = 0;
        seen = 1'b0;
        low_run = 0;
      end else if (dena[idx]) begin
        if (n == 0 && seen) last_gap[idx] = low_run;
        if (msb) w = {w[14:0], dout[idx]};
        else     w = {dout[idx], w[15:1]};
        n++;
        if (n == dw) begin
          got = msb ? (w & mask) : (w >> (16 - dw));
          pop_exp(idx, exp, ok);
          if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL extra_word[%0d]: got %0h, nothing expected", idx, got);
          end else begin
            check($sformatf("word[%0d]", idx), 32'(got), 32'(exp));
          end
          n = 0;
          seen = 1'b1;
          low_run = 0;
          words_seen[idx]++;
        end
      end else begin
        if (n != 0) begin
          check($sformatf("ena_len[%0d]", idx), 32'(n), 32'(dw));
          n = 0;
        end
        if (dout[idx] !== 1'b0) idle_bad++;
        low_run++;
      end
    end
  endtask

  initial begin
    fork
      monitor(0, 8, 1'b1);
      monitor(1, 16, 1'b0);
      monitor(2, 16, 1'b1);
    join_none
  end

  // driver tasks
  task automatic send(input int idx, input logic [15:0] data, input int nlow);
    @(posedge clk); #1;
    bus[idx]  = data;
    nget[idx] = 1'b0;
    repeat (nlow) @(posedge clk);
    #1 nget[idx] = 1'b1;
    @(posedge clk); #1 usep[idx] = 1'b1;
    repeat (5) @(posedge clk);
    #1 usep[idx] = 1'b0;
    @(posedge clk);
  endtask

  task automatic wait_words(input int idx, input int target, input int budget);
    int k = 0;
    while (words_seen[idx] < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("wait_words[%0d]", idx), 32'(words_seen[idx] >= target), 32'd1);
  endtask

  initial begin
    int base;
    int k;
    logic [7:0] d;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nget[i] = 1'b1;
      usep[i] = 1'b0;
      bus[i]  = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_empty[%0d]", i), 32'(emp[i]), 32'd1);
      check($sformatf("rst_full[%0d]", i), 32'(full[i]), 32'd0);
      check($sformatf("rst_ena[%0d]", i), 32'(dena[i]), 32'd0);
      check($sformatf("rst_dout[%0d]", i), 32'(dout[i]), 32'd0);
      check($sformatf("rst_flags[%0d]", i), 32'({ovf[i], orph[i]}), 32'd0);
      check($sformatf("rst_wcnt[%0d]", i), 32'(wcnt[i]), 32'd0);
      check($sformatf("rst_state[%0d]", i), 32'(sdbg[i]), 32'd0);
    end

    // single word with a long request pulse; expected serial 1,0,0,1,1,0,0,1
    push_exp(0, 16'h0099);
    send(0, 16'h0099, 12);
    wait_words(0, 1, 60);
    check("single_wcnt", 32'(wcnt[0]), 32'd1);

    // strobe with no request armed
    @(posedge clk); #1 usep[0] = 1'b1;
    repeat (5) @(posedge clk);
    #1 usep[0] = 1'b0;
    repeat (12) @(negedge clk);
    check("orphan_flag", 32'(orph[0]), 32'd1);
    check("orphan_empty", 32'(emp[0]), 32'd1);
    check("orphan_no_word", 32'(words_seen[0]), 32'd1);

    // reset in the middle of a serial word
    push_exp(0, 16'h00C3);
    send(0, 16'h00C3, 1);
    k = 0;
    while (!dena[0] && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("midshift_reached", 32'(dena[0]), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    exp_q0.delete();
    @(negedge clk);
    @(negedge clk);
    check("midshift_ena_off", 32'(dena[0]), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midshift_empty", 32'(emp[0]), 32'd1);
    check("midshift_wcnt", 32'(wcnt[0]), 32'd0);
    check("midshift_flags", 32'({ovf[0], orph[0]}), 32'd0);
    check("midshift_no_word", 32'(words_seen[0]), 32'd1);

    // soak: 100 pairs, data incrementing from 8'h99; pair spacing stays above the 10-clock word time
    base = words_seen[0];
    for (int i = 0; i < 100; i++) begin
      d = 8'h99 + 8'(i);
      push_exp(0, {8'h00, d});
      send(0, {8'h00, d}, $urandom_range(1, 4));
      repeat ($urandom_range(2, 12)) @(posedge clk);
    end
    wait_words(0, base + 100, 400);
    check("soak_wcnt", 32'(wcnt[0]), 32'd100);
    check("soak_overflow", 32'(ovf[0]), 32'd0);
    check("soak_orphan", 32'(orph[0]), 32'd0);

    // LSB first; second word is queued so the gap between words is exactly GAP clocks
    push_exp(1, 16'h009A);
    push_exp(1, 16'h1234);
    send(1, 16'h009A, 1);
    send(1, 16'h1234, 1);
    wait_words(1, 2, 200);
    check("lsb_gap", 32'(last_gap[1]), 32'd2);
    check("lsb_wcnt", 32'(wcnt[1]), 32'd2);

    // overflow: the first word moves to the shifter one clock after landing,
    // so the sixth pair is the one that finds the 4-deep FIFO full
    for (int i = 0; i < 6; i++) begin
      if (i < 5) push_exp(2, 16'hA000 + 16'(i));
      send(2, 16'hA000 + 16'(i), 1);
    end
    @(negedge clk);
    check("ovf_full", 32'(full[2]), 32'd1);
    check("ovf_flag", 32'(ovf[2]), 32'd1);
    check("ovf_orphan", 32'(orph[2]), 32'd0);
    wait_words(2, 5, 1800);
    repeat (4) @(negedge clk);
    check("ovf_wcnt", 32'(wcnt[2]), 32'd5);
    check("ovf_drained", 32'(emp[2]), 32'd1);
    check("ovf_not_full", 32'(full[2]), 32'd0);
    check("ovf_sticky", 32'(ovf[2]), 32'd1);

    // final report
    check("left_q0", 32'(exp_q0.size()), 32'd0);
    check("left_q1", 32'(exp_q1.size()), 32'd0);
    check("left_q2", 32'(exp_q2.size()), 32'd0);
    check("idle_dout_zero", 32'(idle_bad), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
